// File: rtl/pipe_delay_line_if.sv
// Handshake bundle for pipe_delay_line: upstream beat in, downstream beat out.
//   in_valid/in_data  : upstream beat offered
//   in_ready          : block accepts the upstream beat this cycle
//   out_valid/out_data: downstream beat offered
//   out_ready         : downstream accepts the beat this cycle
// master = surrounding logic (source + sink), slave = the delay line itself.
interface pipe_delay_line_if #(
    parameter int unsigned WIDTH = 1
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage valid/ready register chain with bubble collapse.
// Ports:
//   clk   - sole clock, rising edge
//   rst   - synchronous active-high reset (clears valids, optionally data)
//   flush - synchronous discard of every held beat; same-cycle input dropped
//   bus   - pipe_delay_line_if.slave (in_valid/in_data/in_ready,
//           out_valid/out_data/out_ready)
//   occ   - beats held; live only when PIPE_DELAY_OCC_EN is defined, else 0
// DEPTH = 0 degenerates to plain wiring. in_ready is combinational from
// out_ready through the advance chain.
module pipe_delay_line #(
    parameter int unsigned  WIDTH      = 1,
    parameter int unsigned  DEPTH      = 1,
    parameter int unsigned  RESET_DATA = 1,
    localparam int unsigned OCC_W      = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_delay_line_if.slave bus,
    output logic [OCC_W-1:0] occ
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Pure pass-through; clock, reset and flush have no effect.
            logic unused_ok;
            assign unused_ok     = ^{clk, rst, flush};
            assign bus.out_valid = bus.in_valid;
            assign bus.out_data  = bus.in_data;
            assign bus.in_ready  = bus.out_ready;
            assign occ           = '0;
        end else begin : g_pipe
            logic [DEPTH-1:0] v;
            logic [DEPTH-1:0] adv;
            logic [DEPTH-1:0] src_v;
            logic [WIDTH-1:0] d     [DEPTH];
            logic [WIDTH-1:0] src_d [DEPTH];

            // Advance chain: a stage moves if it is empty or its successor moves.
            always_comb begin : p_adv
                logic go;
                go  = bus.out_ready;
                adv = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    go     = ~v[k] | go;
                    adv[k] = go;
                end
            end

            // What each stage would load: predecessor stage, or the input for stage 0.
            always_comb begin
                src_v    = '0;
                src_d    = '{default: '0};
                src_v[0] = bus.in_valid;
                src_d[0] = bus.in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    src_v[k] = v[k-1];
                    src_d[k] = d[k-1];
                end
            end

            assign bus.in_ready  = adv[0] & ~flush & ~rst;
            assign bus.out_valid = v[DEPTH-1];
            assign bus.out_data  = d[DEPTH-1];

            // Valid bits.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    v <= '0;
                end else begin
                    v <= (adv & src_v) | (~adv & v);
                end
            end

            // Data registers load only real beats, never bubbles or flushed input.
            always_ff @(posedge clk) begin
                if (rst) begin
                    if (RESET_DATA != 0) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            d[k] <= '0;
                        end
                    end
                end else if (!flush) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (adv[k] && src_v[k]) begin
                            d[k] <= src_d[k];
                        end
                    end
                end
            end

`ifdef PIPE_DELAY_OCC_EN
            // Occupancy counter; bounded by DEPTH because in_ready gates entry.
            logic             in_xfer;
            logic             out_xfer;
            logic [OCC_W-1:0] cnt;

            assign in_xfer  = bus.in_valid & bus.in_ready;
            assign out_xfer = bus.out_valid & bus.out_ready;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    cnt <= '0;
                end else if (in_xfer && !out_xfer) begin
                    cnt <= cnt + OCC_W'(1);
                end else if (!in_xfer && out_xfer) begin
                    cnt <= cnt - OCC_W'(1);
                end
            end

            assign occ = cnt;
`else
            assign occ = '0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line: DEPTH 3, DEPTH 2 (both RESET_DATA
// settings) and DEPTH 0 instances, checked against a queue-of-beats model.
module tb_pipe_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_DELAY_OCC_EN
    localparam int OCC_ON = 1;
`else
    localparam int OCC_ON = 0;
`endif

    // Stimulus: group 3 drives the DEPTH=3 unit, group 2 both DEPTH=2 units.
    logic       rst3, fl3, iv3, or3;
    logic [7:0] id3;
    logic       rst2, fl2, iv2, or2;
    logic [7:0] id2;
    logic       iv0, or0, rst0, fl0;
    logic [7:0] id0;

    pipe_delay_line_if #(.WIDTH(8)) b3 ();
    pipe_delay_line_if #(.WIDTH(8)) b2a ();
    pipe_delay_line_if #(.WIDTH(8)) b2b ();
    pipe_delay_line_if #(.WIDTH(8)) b0 ();

    assign b3.in_valid   = iv3;
    assign b3.in_data    = id3;
    assign b3.out_ready  = or3;
    assign b2a.in_valid  = iv2;
    assign b2a.in_data   = id2;
    assign b2a.out_ready = or2;
    assign b2b.in_valid  = iv2;
    assign b2b.in_data   = id2;
    assign b2b.out_ready = or2;
    assign b0.in_valid   = iv0;
    assign b0.in_data    = id0;
    assign b0.out_ready  = or0;

    logic [1:0] occ3, occ2a, occ2b;
    logic       occ0;

    pipe_delay_line #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1)) u3 (
        .clk(clk), .rst(rst3), .flush(fl3), .bus(b3), .occ(occ3));
    pipe_delay_line #(.WIDTH(8), .DEPTH(2), .RESET_DATA(1)) u2a (
        .clk(clk), .rst(rst2), .flush(fl2), .bus(b2a), .occ(occ2a));
    pipe_delay_line #(.WIDTH(8), .DEPTH(2), .RESET_DATA(0)) u2b (
        .clk(clk), .rst(rst2), .flush(fl2), .bus(b2b), .occ(occ2b));
    pipe_delay_line #(.WIDTH(8), .DEPTH(0), .RESET_DATA(1)) u0 (
        .clk(clk), .rst(rst0), .flush(fl0), .bus(b0), .occ(occ0));

    // DUT observation per modelled instance.
    logic       d_ov [3];
    logic       d_ir [3];
    logic [7:0] d_od [3];
    int         d_occ[3];
    assign d_ov[0] = b3.out_valid;  assign d_ir[0] = b3.in_ready;
    assign d_od[0] = b3.out_data;   assign d_occ[0] = int'(occ3);
    assign d_ov[1] = b2a.out_valid; assign d_ir[1] = b2a.in_ready;
    assign d_od[1] = b2a.out_data;  assign d_occ[1] = int'(occ2a);
    assign d_ov[2] = b2b.out_valid; assign d_ir[2] = b2b.in_ready;
    assign d_od[2] = b2b.out_data;  assign d_occ[2] = int'(occ2b);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, an ordered list of held beats (oldest first), each
    // with its stage position. A beat moves forward unless blocked by a beat
    // directly ahead that itself stays; the oldest leaves from the last stage
    // when out_ready is high.
    string      nm[3]      = '{"u3", "u2a", "u2b"};
    int         m_depth[3] = '{3, 2, 2};
    int         m_n[3];
    int         m_pos[3][8];
    logic [7:0] m_dat[3][8];
    bit         m_ok[3];
    bit         m_mv[8];

    task automatic m_eval(input int i, input bit ordy, output bit ov, output int od,
                          output bit free0);
        int dp = m_depth[i];
        ov = (m_n[i] > 0) && (m_pos[i][0] == dp - 1);
        od = ov ? int'(m_dat[i][0]) : 0;
        for (int j = 0; j < m_n[i]; j++) begin
            if (j == 0) m_mv[j] = (m_pos[i][0] == dp - 1) ? ordy : 1'b1;
            else        m_mv[j] = (m_pos[i][j-1] != m_pos[i][j] + 1) || m_mv[j-1];
        end
        free0 = (m_n[i] == 0) || (m_pos[i][m_n[i]-1] > 0) || m_mv[m_n[i]-1];
    endtask

    task automatic m_step(input int i, input bit iv, input logic [7:0] idat,
                          input bit ordy, input bit fl, input bit rs);
        bit ov, f0;
        int od;
        m_eval(i, ordy, ov, od, f0);
        if (rs) begin
            m_n[i]  = 0;
            m_ok[i] = 1'b1;
        end else if (fl) begin
            m_n[i] = 0;
        end else begin
            for (int j = 0; j < m_n[i]; j++) if (m_mv[j]) m_pos[i][j]++;
            if (m_n[i] > 0 && m_pos[i][0] == m_depth[i]) begin
                for (int j = 0; j < m_n[i] - 1; j++) begin
                    m_pos[i][j] = m_pos[i][j+1];
                    m_dat[i][j] = m_dat[i][j+1];
                end
                m_n[i]--;
            end
            if (iv && f0) begin
                m_pos[i][m_n[i]] = 0;
                m_dat[i][m_n[i]] = idat;
                m_n[i]++;
            end
        end
    endtask

    // Compare every cycle at the falling edge, then advance the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit         iv, ordy, fl, rs, ov, f0;
            logic [7:0] idat;
            int         od;
            iv   = (i == 0) ? iv3  : iv2;
            idat = (i == 0) ? id3  : id2;
            ordy = (i == 0) ? or3  : or2;
            fl   = (i == 0) ? fl3  : fl2;
            rs   = (i == 0) ? rst3 : rst2;
            if (m_ok[i] || rs) begin
                m_eval(i, ordy, ov, od, f0);
                chk({nm[i], ".in_ready"}, int'(d_ir[i]), int'(!rs && !fl && f0));
                if (m_ok[i]) begin
                    chk({nm[i], ".out_valid"}, int'(d_ov[i]), int'(ov));
                    if (ov) chk({nm[i], ".out_data"}, int'(d_od[i]), od);
                    chk({nm[i], ".occ"}, d_occ[i], OCC_ON * m_n[i]);
                end
                m_step(i, iv, idat, ordy, fl, rs);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst3 = 1'b1; fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = '0;
        rst2 = 1'b1; fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; id2 = '0;
        iv0 = 1'b0; or0 = 1'b0; id0 = '0; rst0 = 1'b0; fl0 = 1'b0;
        for (int i = 0; i < 3; i++) begin m_n[i] = 0; m_ok[i] = 1'b0; end
        tick(); tick();
        #3;
        chk("rst_in_ready", int'(b3.in_ready), 0);
        chk("rst_out_valid", int'(b3.out_valid), 0);
        chk("rst_out_data", int'(b3.out_data), 0);
        rst3 = 1'b0; rst2 = 1'b0;
        tick();

        // Streaming: three beats back to back, out_ready high.
        or3 = 1'b1; iv3 = 1'b1; id3 = 8'h11; #3 chk("stream_rdy0", int'(b3.in_ready), 1);
        tick(); id3 = 8'h22; #3 chk("stream_rdy1", int'(b3.in_ready), 1);
        tick(); id3 = 8'h33; #3 chk("stream_rdy2", int'(b3.in_ready), 1);
        tick(); iv3 = 1'b0; #3;
        chk("stream_v0", int'(b3.out_valid), 1); chk("stream_d0", int'(b3.out_data), 8'h11);
        tick(); #3 chk("stream_d1", int'(b3.out_data), 8'h22);
        tick(); #3 chk("stream_d2", int'(b3.out_data), 8'h33);
        tick(); #3 chk("stream_end", int'(b3.out_valid), 0);
        tick();

        // Backpressure: DEPTH beats fill the chain, the fourth waits.
        or3 = 1'b0; iv3 = 1'b1; id3 = 8'h01; tick();
        id3 = 8'h02; tick();
        id3 = 8'h03; tick();
        id3 = 8'h04; #2;
        chk("full_rdy", int'(b3.in_ready), 0);
        chk("full_occ", int'(occ3), OCC_ON * 3);
        chk("full_head", int'(b3.out_data), 8'h01);
        or3 = 1'b1; #1 chk("drain_rdy", int'(b3.in_ready), 1);
        tick(); iv3 = 1'b0; #3 chk("drain_d2", int'(b3.out_data), 8'h02);
        tick(); #3 chk("drain_d3", int'(b3.out_data), 8'h03);
        tick(); #3 chk("drain_d4", int'(b3.out_data), 8'h04);
        tick(); #3 chk("drain_end", int'(b3.out_valid), 0);

        // Single beat parks in the last stage while out_ready is low.
        or3 = 1'b0; iv3 = 1'b1; id3 = 8'hAA; tick();
        iv3 = 1'b0; tick(); tick();
        for (int k = 0; k < 3; k++) begin
            #3 chk("park_v", int'(b3.out_valid), 1); chk("park_d", int'(b3.out_data), 8'hAA);
            tick();
        end
        or3 = 1'b1; tick(); #3 chk("park_gone", int'(b3.out_valid), 0);
        tick();

        // Flush with a full chain, a same-cycle input and a same-cycle output.
        or3 = 1'b0; iv3 = 1'b1; id3 = 8'hB1; tick();
        id3 = 8'hB2; tick();
        id3 = 8'hB3; tick();
        id3 = 8'hCC; fl3 = 1'b1; or3 = 1'b1; #3;
        chk("flush_v", int'(b3.out_valid), 1);
        chk("flush_d", int'(b3.out_data), 8'hB1);
        chk("flush_rdy", int'(b3.in_ready), 0);
        tick(); fl3 = 1'b0; iv3 = 1'b0; #3;
        chk("flush_after_v", int'(b3.out_valid), 0);
        chk("flush_after_occ", int'(occ3), 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #3 chk("flush_no_cc", int'(b3.out_valid), 0);
        end
        tick();

        // Mixed random traffic with occasional flush and one mid-stream reset.
        for (int k = 0; k < 80; k++) begin
            iv3  = 1'($urandom % 2);
            id3  = 8'($urandom);
            or3  = ($urandom_range(0, 3) != 0);
            fl3  = (($urandom % 16) == 0);
            rst3 = (k == 40);
            tick();
        end
        rst3 = 1'b0; fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
        repeat (5) tick();

        // DEPTH=2: reset together with flush while holding beats.
        or2 = 1'b0; iv2 = 1'b1; id2 = 8'h5A; tick();
        id2 = 8'h6B; tick();
        iv2 = 1'b0; #3;
        chk("d2a_head", int'(b2a.out_data), 8'h5A);
        chk("d2b_head", int'(b2b.out_data), 8'h5A);
        chk("d2a_full_rdy", int'(b2a.in_ready), 0);
        rst2 = 1'b1; fl2 = 1'b1; tick();
        rst2 = 1'b0; fl2 = 1'b0; #3;
        chk("d2a_rst_v", int'(b2a.out_valid), 0);
        chk("d2a_rst_d", int'(b2a.out_data), 8'h00);
        chk("d2a_rst_occ", int'(occ2a), 0);
        chk("d2b_rst_v", int'(b2b.out_valid), 0);
        chk("d2b_rst_d", int'(b2b.out_data), 8'h5A);
        chk("d2b_rst_occ", int'(occ2b), 0);
        tick();
        for (int k = 0; k < 40; k++) begin
            iv2 = 1'($urandom % 2);
            id2 = 8'($urandom);
            or2 = 1'($urandom % 2);
            fl2 = (($urandom % 12) == 0);
            tick();
        end
        fl2 = 1'b0; iv2 = 1'b0;

        // DEPTH=0: pure wiring.
        for (int k = 0; k < 50; k++) begin
            iv0 = 1'($urandom % 2);
            id0 = 8'($urandom);
            or0 = 1'($urandom % 2);
            #3;
            chk("w0_valid", int'(b0.out_valid), int'(iv0));
            chk("w0_data", int'(b0.out_data), int'(id0));
            chk("w0_ready", int'(b0.in_ready), int'(or0));
            chk("w0_occ", int'(occ0), 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_delay_line.md
PIPE_DELAY_LINE -- requirements
Module: pipe_delay_line

Interface
REQ-001 Parameter WIDTH, default 1, data bits per beat (WIDTH >= 1).
REQ-002 Parameter DEPTH, default 1, number of register stages (DEPTH >= 0).
REQ-003 Parameter RESET_DATA, default 1, 1 = data registers cleared to 0 on reset, 0 = data registers not reset.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held beats.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_data  input  WIDTH  upstream beat payload.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_data  output  WIDTH  downstream beat payload.
REQ-012 out_ready  input  1  downstream accepts a beat this cycle.
REQ-013 occ  output  $clog2(DEPTH+1), min 1  number of beats held.

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-015 DEPTH = 0 is selected by a generate branch and is pure wiring: out_valid = in_valid, out_data = in_data, in_ready = out_ready, occ = 0, flush ignored.
REQ-016 DEPTH >= 1: stage k holds valid bit v[k] and data d[k]; out_valid = v[DEPTH-1], out_data = d[DEPTH-1].
REQ-017 Stage k advances (adv[k]) when v[k] = 0, or k = DEPTH-1 and out_ready = 1, or k < DEPTH-1 and adv[k+1] = 1.
REQ-018 On adv[k], stage k loads v[k-1]/d[k-1] (stage 0 loads in_valid/in_data); otherwise it holds.
REQ-019 in_ready = adv[0] & ~flush, combinational through the chain from out_ready.
REQ-020 Bubbles collapse: an empty stage accepts its predecessor regardless of out_ready.
REQ-021 Latency in_data to out_data is exactly DEPTH cycles when out_ready stays 1; throughput is one beat per cycle.
REQ-022 With out_ready = 0 the block accepts exactly DEPTH beats, then in_ready = 0; no beat is dropped or duplicated, and order is preserved.
REQ-023 Data registers of stages with v[k] = 0 do not load (no toggling on bubbles).
REQ-024 flush = 1 clears all v[k] next cycle, drops any same-cycle input, and still completes a same-cycle out transfer.

Reset
REQ-025 rst = 1 on a rising edge clears all v[k] and occ; out_valid = 0 the cycle after.
REQ-026 With RESET_DATA = 1, all d[k] are cleared to 0; with RESET_DATA = 0, d[k] is unaffected by rst.
REQ-027 rst takes priority over flush and any transfer in the same cycle.
REQ-028 While rst = 1, in_ready = 0.
REQ-029 Reset mid-operation discards all held beats, with no partial output afterwards.

Configuration
REQ-030 Macro PIPE_DELAY_OCC_EN, when defined, compiles in an occupancy counter: +1 on in transfer only, -1 on out transfer only, unchanged on both or neither, 0 after flush or rst; occ never exceeds DEPTH.
REQ-031 Without PIPE_DELAY_OCC_EN, occ is tied to 0 and no counter logic exists.
REQ-032 Data-path behaviour is identical with and without the macro.

Verification
REQ-033 WIDTH=8, DEPTH=3, out_ready=1, inputs 0x11,0x22,0x33 on consecutive cycles -> out 0x11,0x22,0x33 on cycles 3,4,5, with in_ready constantly 1.
REQ-034 WIDTH=8, DEPTH=3, out_ready=0, push 0x01..0x04 -> 0x01..0x03 are accepted, in_ready=0 at the 4th beat, occ=3 (macro on); raise out_ready -> 0x01,0x02,0x03,0x04 in order.
REQ-035 DEPTH=3, beat 0xAA then two idle cycles, out_ready=0 -> 0xAA reaches stage 2 and waits, out_valid=1, out_data=0xAA held stable until out_ready=1.
REQ-036 DEPTH=3 holding 3 beats, flush=1 with in_valid=1, out_ready=1 -> one out transfer that cycle, then out_valid=0, occ=0, and the incoming beat never appears.
REQ-037 DEPTH=2 holding beats, rst=1 with flush=1 -> out_valid=0, occ=0, out_data=0 when RESET_DATA=1 and unchanged when RESET_DATA=0.
REQ-038 DEPTH=0, toggle in_valid/in_data/out_ready randomly for 50 cycles -> outputs equal inputs combinationally, in_ready==out_ready, occ=0.
